dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_if.sv | 27 ++
 rtl/dmem_ctrl.sv | 130 +++++++++++++
 tb/tb_dmem_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Request/response and data-memory bus bundle for dmem_ctrl.
// The master side is the pipeline plus memory array; the slave side is the controller.
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_rdata;
    logic        stall;
    logic        fault;
    logic        mem_read;
    logic        mem_write;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_rdata, stall, fault, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_rdata, stall, fault, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// RV32I data-memory controller: single-cycle loads/word stores, read-modify-write byte/half stores.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of aligning them.
module dmem_ctrl (
    input logic         clk,
    input logic         reset,
    dmem_ctrl_if.slave  bus
);

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t      state;
    logic [31:0] merge_q;

    logic [1:0]  size;
    logic        load_legal;
    logic        store_legal;
    logic        legal;
    logic        misaligned;
    logic [1:0]  eff_off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] merge_d;
    logic        start_rmw;

    // Decode size/legality and the lane offset the access really uses
    always_comb begin
        size        = bus.req_funct3[1:0];
        load_legal  = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                      (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                      (bus.req_funct3 == 3'b101);
        store_legal = !bus.req_funct3[2] && (bus.req_funct3[1:0] != 2'b11);
        legal       = bus.req_write ? store_legal : load_legal;
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned  = ((size == 2'b01) && bus.req_addr[0]) ||
                      ((size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
        misaligned  = 1'b0;
`endif
        case (size)
            2'b00:   eff_off = bus.req_addr[1:0];
            2'b01:   eff_off = {bus.req_addr[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
    end

    // Lane extraction for loads and lane insertion for sub-word stores
    always_comb begin
        case (eff_off)
            2'b00:   byte_sel = bus.mem_rdata[7:0];
            2'b01:   byte_sel = bus.mem_rdata[15:8];
            2'b10:   byte_sel = bus.mem_rdata[23:16];
            default: byte_sel = bus.mem_rdata[31:24];
        endcase
        half_sel = eff_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

        case (size)
            2'b00:   load_data = bus.req_funct3[2] ? {24'h0, byte_sel}
                                                   : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_data = bus.req_funct3[2] ? {16'h0, half_sel}
                                                   : {{16{half_sel[15]}}, half_sel};
            default: load_data = bus.mem_rdata;
        endcase

        merge_d = bus.mem_rdata;
        if (size == 2'b00) begin
            case (eff_off)
                2'b00:   merge_d[7:0]   = bus.req_wdata[7:0];
                2'b01:   merge_d[15:8]  = bus.req_wdata[7:0];
                2'b10:   merge_d[23:16] = bus.req_wdata[7:0];
                default: merge_d[31:24] = bus.req_wdata[7:0];
            endcase
        end else if (eff_off[1]) begin
            merge_d[31:16] = bus.req_wdata[15:0];
        end else begin
            merge_d[15:0] = bus.req_wdata[15:0];
        end
    end

    assign start_rmw = (state == IDLE) && bus.req_valid && bus.req_write && legal &&
                       !misaligned && (size != 2'b10);

    // Reset overrides everything, which also drops the write of an abandoned RMW
    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_wdata = 32'h0;
        bus.mem_addr  = bus.req_addr[10:2];
        bus.stall     = 1'b0;
        bus.fault     = 1'b0;
        bus.req_rdata = 32'h0;
        if (!reset) begin
            if (state == RMW_WR) begin
                bus.mem_write = 1'b1;
                bus.mem_wdata = merge_q;
            end else if (bus.req_valid) begin
                if (!legal || misaligned) begin
                    bus.fault = 1'b1;
                end else if (!bus.req_write) begin
                    bus.mem_read  = 1'b1;
                    bus.req_rdata = load_data;
                end else if (size == 2'b10) begin
                    bus.mem_write = 1'b1;
                    bus.mem_wdata = bus.req_wdata;
                end else begin
                    bus.mem_read = 1'b1;
                    bus.stall    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            merge_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_rmw) begin
                        merge_q <= merge_d;
                        state   <= RMW_WR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: per-cycle behavioural model plus directed literal checks.
// Honours DMEM_MISALIGN_TRAP_EN the same way the design does.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   acc_count = 0;
    bit   pend = 1'b0;
    logic [31:0] pend_word = 32'h0;

    dmem_ctrl_if bus ();

    dmem_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit w, input logic [2:0] f3,
                                 input logic [10:0] a, input logic [31:0] wd, input logic [31:0] rd);
        @(posedge clk);
        #1;
        bus.req_valid  = v;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.mem_rdata  = rd;
        #1;
    endtask

    // Model: what the controller must do this cycle, from access size and byte offset arithmetic
    always @(negedge clk) begin
        logic [31:0] e_rd, e_wd, mask, val;
        bit e_read, e_write, e_stall, e_fault, ok, mis;
        int nbytes, off;
        e_rd = 0; e_wd = 0; e_read = 0; e_write = 0; e_stall = 0; e_fault = 0;
        nbytes = 1 << bus.req_funct3[1:0];
        off = 0;
        if (reset) begin
            pend = 1'b0;
        end else if (pend) begin
            e_write = 1; e_wd = pend_word;
            pend = 1'b0;
        end else if (bus.req_valid) begin
            if (bus.req_write) ok = (bus.req_funct3 <= 3'd2);
            else ok = (bus.req_funct3 != 3'd3) && (bus.req_funct3 != 3'd6) && (bus.req_funct3 != 3'd7);
`ifdef DMEM_MISALIGN_TRAP_EN
            mis = (nbytes > 1) && ((int'(bus.req_addr) % nbytes) != 0);
`else
            mis = 1'b0;
`endif
            off = (int'(bus.req_addr) % 4) / nbytes * nbytes;
            mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
            if (!ok || mis) begin
                e_fault = 1;
            end else if (!bus.req_write) begin
                e_read = 1;
                val = (bus.mem_rdata >> (8 * off)) & mask;
                if (!bus.req_funct3[2] && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
                e_rd = val;
            end else if (nbytes == 4) begin
                e_write = 1; e_wd = bus.req_wdata;
            end else begin
                e_read = 1; e_stall = 1;
                pend = 1'b1;
                pend_word = (bus.mem_rdata & ~(mask << (8 * off))) |
                            ((bus.req_wdata & mask) << (8 * off));
            end
        end
        checkOutput("m.mem_read",  {31'h0, bus.mem_read},  {31'h0, e_read});
        checkOutput("m.mem_write", {31'h0, bus.mem_write}, {31'h0, e_write});
        checkOutput("m.stall",     {31'h0, bus.stall},     {31'h0, e_stall});
        checkOutput("m.fault",     {31'h0, bus.fault},     {31'h0, e_fault});
        checkOutput("m.req_rdata", bus.req_rdata, e_rd);
        checkOutput("m.mem_addr",  {23'h0, bus.mem_addr}, {21'h0, bus.req_addr} >> 2);
        if (e_write) checkOutput("m.mem_wdata", bus.mem_wdata, e_wd);
        checkOutput("m.rw_excl", {31'h0, bus.mem_read & bus.mem_write}, 32'h0);
        acc_count += int'(bus.mem_read) + int'(bus.mem_write);
    end

    initial begin
        int c0;
        bus.req_valid = 0; bus.req_write = 0; bus.req_funct3 = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.mem_rdata = 0;

        // Reset holds outputs quiet even with a live request
        applyStimulus(1, 0, 3'b010, 11'h010, 32'h0, 32'hDEADBEEF);
        checkOutput("rst.mem_read", {31'h0, bus.mem_read}, 32'h0);
        checkOutput("rst.req_rdata", bus.req_rdata, 32'h0);
        applyStimulus(0, 0, 3'b000, 11'h000, 32'h0, 32'h0);
        @(posedge clk); #1; reset = 0;

        applyStimulus(1, 0, 3'b010, 11'h010, 32'h0, 32'hDEADBEEF);
        checkOutput("lw.mem_addr", {23'h0, bus.mem_addr}, 32'd4);
        checkOutput("lw.req_rdata", bus.req_rdata, 32'hDEADBEEF);
        checkOutput("lw.stall", {31'h0, bus.stall}, 32'h0);

        applyStimulus(1, 0, 3'b000, 11'h013, 32'h0, 32'h80112233);
        checkOutput("lb.req_rdata", bus.req_rdata, 32'hFFFFFF80);
        applyStimulus(1, 0, 3'b100, 11'h013, 32'h0, 32'h80112233);
        checkOutput("lbu.req_rdata", bus.req_rdata, 32'h00000080);
        applyStimulus(1, 0, 3'b001, 11'h012, 32'h0, 32'h80017FFF);
        checkOutput("lh.req_rdata", bus.req_rdata, 32'hFFFF8001);
        applyStimulus(1, 0, 3'b101, 11'h012, 32'h0, 32'h80017FFF);
        checkOutput("lhu.req_rdata", bus.req_rdata, 32'h00008001);

        applyStimulus(1, 1, 3'b000, 11'h005, 32'h000000AB, 32'h11223344);
        checkOutput("sb.stall", {31'h0, bus.stall}, 32'd1);
        applyStimulus(1, 1, 3'b000, 11'h005, 32'h000000AB, 32'h11223344);
        checkOutput("sb.mem_write", {31'h0, bus.mem_write}, 32'd1);
        checkOutput("sb.mem_wdata", bus.mem_wdata, 32'h1122AB44);
        checkOutput("sb.mem_addr", {23'h0, bus.mem_addr}, 32'd1);

        applyStimulus(0, 0, 3'b000, 11'h000, 32'h0, 32'h55555555);
        checkOutput("idle.req_rdata", bus.req_rdata, 32'h0);

        // Reset lands on the write cycle of a halfword RMW
        applyStimulus(1, 1, 3'b001, 11'h002, 32'h00005566, 32'h11223344);
        checkOutput("sh.stall", {31'h0, bus.stall}, 32'd1);
        @(posedge clk); #1; reset = 1; #1;
        checkOutput("shrst.mem_write", {31'h0, bus.mem_write}, 32'h0);
        checkOutput("shrst.stall", {31'h0, bus.stall}, 32'h0);
        @(posedge clk); #1; reset = 0; bus.req_valid = 0; #1;
        checkOutput("post.mem_write", {31'h0, bus.mem_write}, 32'h0);

        applyStimulus(1, 0, 3'b010, 11'h006, 32'h0, 32'h01020304);
`ifdef DMEM_MISALIGN_TRAP_EN
        checkOutput("lwmis.fault", {31'h0, bus.fault}, 32'd1);
        checkOutput("lwmis.mem_read", {31'h0, bus.mem_read}, 32'h0);
`else
        checkOutput("lwmis.mem_read", {31'h0, bus.mem_read}, 32'd1);
        checkOutput("lwmis.mem_addr", {23'h0, bus.mem_addr}, 32'd1);
        checkOutput("lwmis.fault", {31'h0, bus.fault}, 32'h0);
`endif
        applyStimulus(1, 1, 3'b001, 11'h003, 32'h0000BEEF, 32'h11223344);
        applyStimulus(1, 1, 3'b001, 11'h003, 32'h0000BEEF, 32'h11223344);
`ifndef DMEM_MISALIGN_TRAP_EN
        checkOutput("shmis.mem_wdata", bus.mem_wdata, 32'hBEEF3344);
`endif

        applyStimulus(1, 1, 3'b100, 11'h008, 32'h1, 32'h0);
        checkOutput("sill.fault", {31'h0, bus.fault}, 32'd1);
        applyStimulus(1, 0, 3'b011, 11'h008, 32'h0, 32'h12345678);
        checkOutput("lill.mem_read", {31'h0, bus.mem_read}, 32'h0);
        applyStimulus(1, 0, 3'b110, 11'h008, 32'h0, 32'h12345678);

        // SB then SW with no gap: three memory accesses in three cycles
        c0 = acc_count;
        applyStimulus(1, 1, 3'b000, 11'h008, 32'h00000012, 32'hAABBCCDD);
        applyStimulus(1, 1, 3'b000, 11'h008, 32'h00000012, 32'hAABBCCDD);
        checkOutput("b2b.rmw_wdata", bus.mem_wdata, 32'hAABBCC12);
        applyStimulus(1, 1, 3'b010, 11'h00C, 32'hCAFEF00D, 32'h0);
        checkOutput("b2b.sw_write", {31'h0, bus.mem_write}, 32'd1);
        checkOutput("b2b.sw_stall", {31'h0, bus.stall}, 32'h0);
        @(negedge clk); #1;
        checkOutput("b2b.accesses", acc_count - c0, 32'd3);
        bus.req_valid = 0;

        applyStimulus(1, 1, 3'b001, 11'h7FE, 32'h0000A5A5, 32'h00FF00FF);
        applyStimulus(1, 1, 3'b001, 11'h7FE, 32'h0000A5A5, 32'h00FF00FF);
        checkOutput("shtop.mem_wdata", bus.mem_wdata, 32'hA5A500FF);
        applyStimulus(0, 0, 3'b000, 11'h000, 32'h0, 32'h0);
        applyStimulus(0, 0, 3'b000, 11'h000, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
